// File: rtl/rx_fifo_pkg.sv
// rtl/rx_fifo_pkg.sv - shared UART receive-path constants (receiver framing and FIFO geometry)
//
// Holds the defaults used by the UART receiver and the receive FIFO:
//   DBIT, SB_TICK    : receiver data bits per frame and oversample ticks per stop bit
//   FIFO_DATA_WIDTH  : FIFO word width (matches receiver dout)
//   FIFO_ADDR_WIDTH  : FIFO pointer width; depth is 2**FIFO_ADDR_WIDTH
package rx_fifo_pkg;

  localparam int DBIT            = 8;
  localparam int SB_TICK         = 16;

  localparam int FIFO_DATA_WIDTH = DBIT;
  localparam int FIFO_ADDR_WIDTH = 4;

endpackage

// File: rtl/fifo_reg_file.sv
// rtl/fifo_reg_file.sv - FIFO storage array with one write port and an asynchronous read port
//
// Ports:
//   clk    : write clock
//   we     : write enable, array[waddr] <= wdata on the rising edge
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : combinational read of array[raddr]
// The array is deliberately not reset; emptiness is tracked by the owner.
module fifo_reg_file
  import rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - first-word-fall-through receive FIFO with sticky overflow flag
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-high reset (pointers, count, overflow)
//   wr       : write strobe (receiver rx_done_tick)
//   w_data   : word to store, sampled while wr is high
//   rd       : pop strobe, one word per cycle
//   clr_ovf  : synchronous clear of overflow
//   r_data   : head-of-queue word, valid while empty is low
//   empty    : no words held
//   full     : 2**ADDR_WIDTH words held
//   count    : number of words held
//   overflow : sticky, set when a write is dropped
module rx_fifo
  import rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  input  logic                  clr_ovf,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  drop;

  // Flags decode only the count register, so wr/rd never reach them combinationally.
  assign empty = (count == '0);
  assign full  = (count == DEPTH);

  // A pop frees the slot in the same edge, so a write while full is still
  // accepted when rd is high; a pop on empty is simply ignored.
  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd);
  assign drop  = wr && full && !rd;

  fifo_reg_file #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_reg_file (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (w_ptr),
    .wdata (w_data),
    .raddr (r_ptr),
    .rdata (r_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr    <= '0;
      r_ptr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // Pointers are exactly ADDR_WIDTH wide, so the increment wraps naturally.
      if (wr_ok) begin
        w_ptr <= w_ptr + 1'b1;
      end
      if (rd_ok) begin
        r_ptr <= r_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as clr_ovf keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_fifo.sv
// tb/tb_rx_fifo.sv - self-checking bench for rx_fifo (depth 4) against a queue model
module tb_rx_fifo;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr;
  logic [DW-1:0] w_data;
  logic          rd;
  logic          clr_ovf;
  logic [DW-1:0] r_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: the FIFO contents as a queue plus the sticky flag.
  logic [DW-1:0] mq[$];
  logic          m_ovf;

  rx_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .w_data   (w_data),
    .rd       (rd),
    .clr_ovf  (clr_ovf),
    .r_data   (r_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " count"}, 32'(count), 32'(mq.size()));
    chk({tag, " empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, " full"}, 32'(full), 32'(mq.size() == DEPTH));
    chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) begin
      chk({tag, " r_data"}, 32'(r_data), 32'(mq[0]));
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, check outputs.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic c, input string tag);
    int sz;
    wr = w; w_data = d; rd = r; clr_ovf = c;
    @(posedge clk);
    sz = mq.size();
    if (r && sz > 0) void'(mq.pop_front());
    if (w && (sz < DEPTH || r)) mq.push_back(d);
    if (w && sz == DEPTH && !r) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    #1;
    wr = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
    check_state(tag);
  endtask

  task automatic pop_expect(input logic [DW-1:0] exp, input string tag);
    chk({tag, " head"}, 32'(r_data), 32'(exp));
    cycle(1'b0, 8'h00, 1'b1, 1'b0, tag);
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; w_data = '0; rd = 1'b0; clr_ovf = 1'b0;
    m_ovf = 1'b0;
    #12;
    check_state("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Three writes then three pops in order.
    cycle(1'b1, 8'hA1, 1'b0, 1'b0, "w1");
    cycle(1'b1, 8'hB2, 1'b0, 1'b0, "w2");
    cycle(1'b1, 8'hC3, 1'b0, 1'b0, "w3");
    chk("three count", 32'(count), 32'd3);
    pop_expect(8'hA1, "p1");
    pop_expect(8'hB2, "p2");
    pop_expect(8'hC3, "p3");
    chk("three drained", 32'(empty), 32'd1);

    // Fill, drop one, drain, clear overflow.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "fill");
    chk("fill full", 32'(full), 32'd1);
    cycle(1'b1, 8'h14, 1'b0, 1'b0, "drop");
    chk("drop ovf", 32'(overflow), 32'd1);
    chk("drop count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) pop_expect(8'(8'h10 + i), "drain");
    chk("ovf held", 32'(overflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr");
    chk("ovf cleared", 32'(overflow), 32'd0);

    // Simultaneous rd/wr while full.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "fill2");
    cycle(1'b1, 8'h55, 1'b1, 1'b0, "rw full");
    chk("rw full count", 32'(count), 32'd4);
    chk("rw full ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 4; i++) pop_expect(8'(8'h20 + i), "drain2");
    pop_expect(8'h55, "last 55");

    // Simultaneous rd/wr while empty, then rd alone on empty.
    cycle(1'b1, 8'h77, 1'b1, 1'b0, "rw empty");
    chk("rw empty data", 32'(r_data), 32'h77);
    chk("rw empty count", 32'(count), 32'd1);
    pop_expect(8'h77, "pop 77");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "rd empty");
    chk("rd empty ovf", 32'(overflow), 32'd0);

    // Ten write/pop pairs walk the pointers around the ring twice.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0, "pair w");
      chk("pair bound", 32'(count <= 3'd1), 32'd1);
      pop_expect(8'(i), "pair r");
    end

    // Drive two received bytes, reset mid-operation, then one more byte.
    cycle(1'b1, 8'h3C, 1'b0, 1'b0, "rx1");
    cycle(1'b1, 8'hE7, 1'b0, 1'b0, "rx2");
    chk("rx count2", 32'(count), 32'd2);
    reset = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    chk("async reset empty", 32'(empty), 32'd1);
    chk("async reset count", 32'(count), 32'd0);
    #1;
    reset = 1'b0;
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, "post reset w");
    pop_expect(8'h5A, "post reset r");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each stored word; matches the UART receiver dout width.
REQ-002 Parameter ADDR_WIDTH, default 4, pointer width; depth is 2**ADDR_WIDTH words (16 by default).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr  input  1  write strobe, one clk wide; driven directly by the receiver's rx_done_tick.
REQ-006 w_data  input  DATA_WIDTH  word to store; driven by the receiver's dout and sampled in the cycle wr is high.
REQ-007 rd  input  1  pop strobe from the consumer; one word is removed per clk cycle in which rd is high.
REQ-008 clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-009 r_data  output  DATA_WIDTH  head-of-queue word; first-word-fall-through.
REQ-010 empty  output  1  high when the FIFO holds 0 words.
REQ-011 full  output  1  high when the FIFO holds 2**ADDR_WIDTH words.
REQ-012 count  output  ADDR_WIDTH+1  number of words held, 0..2**ADDR_WIDTH.
REQ-013 overflow  output  1  sticky flag; set when a write is dropped.

Function
REQ-014 Storage: register array of 2**ADDR_WIDTH x DATA_WIDTH, plus write pointer, read pointer and count registers.
REQ-015 r_data: combinational read of array[read pointer]; valid whenever empty=0; its value is unspecified when empty=1.
REQ-016 Accepted write (wr=1, full=0): array[write pointer] <= w_data; write pointer increments modulo 2**ADDR_WIDTH; takes effect on the next clk edge.
REQ-017 Accepted read (rd=1, empty=0): read pointer increments modulo 2**ADDR_WIDTH; the next word appears on r_data one cycle after the rd edge.
REQ-018 Pointer wrap: the increment from 2**ADDR_WIDTH-1 to 0 occurs with no bubble and no data loss.
REQ-019 Read when empty: ignored; pointers and count are unchanged; no error flag is raised.
REQ-020 Write when full with rd=0: the word is dropped, pointers are unchanged, and overflow <= 1 on that edge.
REQ-021 rd=1 and wr=1 while empty: only the write is accepted; count 0->1; the read is ignored.
REQ-022 rd=1 and wr=1 while full: both are accepted; count stays at full; overflow is not set.
REQ-023 rd=1 and wr=1 otherwise: both are accepted; count is unchanged; both pointers advance.
REQ-024 count: +1 on an accepted write only, -1 on an accepted read only, unchanged otherwise; it never exceeds 2**ADDR_WIDTH and never underflows.
REQ-025 empty is (count==0) and full is (count==2**ADDR_WIDTH), both registered-equivalent with no combinational path from wr or rd.
REQ-026 overflow: set per REQ-020 and held until clr_ovf=1 clears it on the next edge; if a drop and clr_ovf occur in the same cycle, set wins.
REQ-027 Throughput: one write and one read per clk cycle sustained; latency from an accepted write into an empty FIFO to valid r_data with empty=0 is 1 cycle.

Reset
REQ-028 On reset assertion, independent of clk: pointers=0, count=0, empty=1, full=0, overflow=0.
REQ-029 Array contents are not reset.
REQ-030 Reset asserted mid-operation discards all stored words immediately; the first write after release lands at address 0.

Structure
REQ-031 DATA_WIDTH and ADDR_WIDTH defaults live in the shared UART package/include alongside the receiver's DBIT/SB_TICK constants.
REQ-032 One sub-module, fifo_reg_file, holds the array with a write port and an asynchronous read port; pointer, count and flag logic stay in rx_fifo.

Verification (ADDR_WIDTH=2, depth 4)
REQ-033 Reset, then write 0xA1, 0xB2, 0xC3 -> count=3, r_data=0xA1; pop 3 times -> reads 0xA1, 0xB2, 0xC3 in order, then empty=1.
REQ-034 Write 0x10..0x13 -> full=1, count=4; write 0x14 -> dropped, overflow=1, count=4; pop all -> 0x10..0x13; pulse clr_ovf -> overflow=0.
REQ-035 Fill with 4 words, then assert rd=1 and wr=1 (0x55) together -> count stays 4, overflow=0; the last word popped is 0x55.
REQ-036 When empty, assert rd=1 and wr=1 (0x77) together -> count=1, r_data=0x77 next cycle; rd alone on empty -> no change.
REQ-037 Run 10 write/pop pairs with data 0x00..0x09 (pointer wrap ×2) -> data order preserved and count never exceeds 1.
REQ-038 Drive the receiver with bytes 0x3C and 0xE7 feeding wr/w_data, then assert reset while count=2 -> empty=1 immediately; the next byte is read back correctly.
